cpu_controller: RTL
===================

// Module: cpu_controller
// PURPOSE
//  Multi-cycle control FSM driving the CPU datapath: fetch, decode, execute.
//  Consumes the instruction register and status flags from the datapath.
//  Produces every datapath strobe and select per cycle.
//  Sits beside the datapath in the CPU top level; the datapath has no sequencing of its own.
// PARAMETERS
//  regFile_addrSize  3   register-file address width
//  busSize           16  instruction/bus width
//  dataWordSize      8   data word / status width
// PORTS
//  clock         in   1   system clock, rising edge
//  nRst          in   1   asynchronous active-low reset
//  run           in   1   1 = sequence; 0 = hold in FETCH0 between instructions
//  IRIn          in   16  IR contents from the datapath
//  StatusIn      in   8   status register: [5]OV [4]C [3]B [2]T [1]Z [0]DIV0
//  a1,a2,aWrite  out  3   register-file read/write addresses
//  selMuxDataReg out  1   constant 0 (low-byte write-back)
//  loadB2MB      out  1   constant 0
//  loadReg       out  1   register-file write strobe
//  incPC,loadPCL,loadPCH  out 1 each  PC control
//  loadIRL,loadIRH        out 1 each  IR load
//  selMux1       out  2   0=regOut2, 1=PC, 2=IR[7:0], 3=zero
//  selMux2       out  3   0=ALU,1=BTNL,2=BTNH,3=SR,4=bus1,5=LR,6=iMem,7=dMem
//  loadLR,loadSR out  1   link / segment register loads
//  iWrite        out  1   constant 0
//  dWrite        out  1   data-memory write strobe
//  loadLEDH,loadLEDL out 1 LED register loads
//  opcode        out  5   ALU opcode (IR[15:11] in ALU EXEC, else 0)
//  func          out  2   ALU function (IR[1:0] in ALU EXEC, else 0)
//  loadStatus    out  1   status register load
//  halted        out  1   1 while in HALT
//  illegal       out  1   1-cycle pulse in EXEC for an undefined opcode
// BEHAVIOUR
//  - Reset: state=FETCH0; every output 0.
//  - Outputs are combinational from the state register and IRIn.
//  - Every strobe is a single-cycle pulse; no output is registered.
//  - Encoding: op=IR[15:11], rd=IR[10:8], rs=IR[7:5], imm=IR[7:0].
//  - States: FETCH0 -> FETCH1 -> EXEC -> (EXEC2) -> FETCH0; HALT.
//  - FETCH0: no strobes; synchronous instruction RAM reads at PC.
//    Leave only if run=1; otherwise stay.
//  - FETCH1: selMux2=6, loadIRH=loadIRL=1, incPC=1 -> EXEC.
//  - EXEC / EXEC2 by op:
//    00000 NOP: no strobes.
//    00001-01111 ALU: a1=rd, a2=rs, selMux1=0, opcode=op, func=IR[1:0],
//      selMux2=0, aWrite=rd, loadReg=1, loadStatus=1.
//    10000 LDI: selMux1=2, selMux2=4, aWrite=rd, loadReg=1.
//    10001 LD: EXEC has no strobes (dMem read at {SR[1:0],imm}).
//      EXEC2: selMux2=7, aWrite=rd, loadReg=1.
//    10010 ST: a2=rd, selMux1=0, dWrite=1.
//    10011 LDSR: a2=rd, selMux1=0, loadSR=1.
//    10100 IN: selMux2 = IR[0]?2:1, aWrite=rd, loadReg=1.
//    10101 OUT: a2=rd, selMux1=0, selMux2=4; IR[0]?loadLEDH:loadLEDL.
//    10110 JMP: selMux1=2, selMux2=4, loadPCL=loadPCH=1 (PC=16'h00imm).
//    10111 JZ: as JMP if StatusIn[1]=1, else no strobes.
//    11000 CALL: EXEC: selMux1=1, loadLR=1 (LR=PC+2). EXEC2: as JMP.
//    11001 RET: selMux2=5, loadPCL=loadPCH=1.
//    11111 HALT: -> HALT.
//    Other op: no strobes, illegal=1.
//  - Cycle counts: 3 cycles per instruction; LD and CALL take 4.
//  - Status written in an ALU EXEC is visible to a JZ that immediately follows.
//  - HALT is left only by reset; all strobes stay 0 in HALT.
//  - run=0 pauses only at FETCH0; an instruction in flight always completes.
//  - nRst low in any state: immediately FETCH0, all outputs 0, no partial write.
// TESTING
//  - Reset: nRst=0 in EXEC of ST -> dWrite=0 that cycle; state FETCH0 after release.
//  - Fetch: run=1 -> FETCH1 shows selMux2=6, loadIRH=loadIRL=incPC=1; EXEC one cycle later.
//  - ALU: IR=16'h0920 (op 00001, rd=1, rs=1) -> EXEC a1=1, a2=1, opcode=1,
//    loadReg=1, loadStatus=1, aWrite=1.
//  - JZ: IR=16'hB844 with StatusIn=8'h02 -> loadPCL=loadPCH=1;
//    with StatusIn=8'h00 -> no strobes.
//  - LD: IR=16'h8A10 -> 4 cycles; only EXEC2 has selMux2=7, aWrite=2, loadReg=1.
//  - CALL, then RET, then HALT: EXEC loadLR=1, selMux1=1; EXEC2 PC load;
//    RET selMux2=5; HALT -> halted=1 and stays with run=1.

Source files
------------

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the CPU datapath.
// All strobes and selects are decoded combinationally from the state register and the IR.
module cpu_controller #(
  parameter int unsigned regFile_addrSize = 3,
  parameter int unsigned busSize          = 16,
  parameter int unsigned dataWordSize     = 8
) (
  input  logic                        clock,
  input  logic                        nRst,
  input  logic                        run,
  input  logic [busSize-1:0]          IRIn,
  input  logic [dataWordSize-1:0]     StatusIn,
  output logic [regFile_addrSize-1:0] a1,
  output logic [regFile_addrSize-1:0] a2,
  output logic [regFile_addrSize-1:0] aWrite,
  output logic                        selMuxDataReg,
  output logic                        loadB2MB,
  output logic                        loadReg,
  output logic                        incPC,
  output logic                        loadPCL,
  output logic                        loadPCH,
  output logic                        loadIRL,
  output logic                        loadIRH,
  output logic [1:0]                  selMux1,
  output logic [2:0]                  selMux2,
  output logic                        loadLR,
  output logic                        loadSR,
  output logic                        iWrite,
  output logic                        dWrite,
  output logic                        loadLEDH,
  output logic                        loadLEDL,
  output logic [4:0]                  opcode,
  output logic [1:0]                  func,
  output logic                        loadStatus,
  output logic                        halted,
  output logic                        illegal
);

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10010;
  localparam logic [4:0] OP_LDSR = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10100;
  localparam logic [4:0] OP_OUT  = 5'b10101;
  localparam logic [4:0] OP_JMP  = 5'b10110;
  localparam logic [4:0] OP_JZ   = 5'b10111;
  localparam logic [4:0] OP_CALL = 5'b11000;
  localparam logic [4:0] OP_RET  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] M1_REG  = 2'd0;
  localparam logic [1:0] M1_PC   = 2'd1;
  localparam logic [1:0] M1_IMM  = 2'd2;

  localparam logic [2:0] M2_ALU  = 3'd0;
  localparam logic [2:0] M2_BTNL = 3'd1;
  localparam logic [2:0] M2_BTNH = 3'd2;
  localparam logic [2:0] M2_BUS1 = 3'd4;
  localparam logic [2:0] M2_LR   = 3'd5;
  localparam logic [2:0] M2_IMEM = 3'd6;
  localparam logic [2:0] M2_DMEM = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [4:0]                  w_op;
  logic [regFile_addrSize-1:0] w_rd;
  logic [regFile_addrSize-1:0] w_rs;
  logic                        w_zero;
  logic                        w_unused;

  assign w_op     = IRIn[15:11];
  assign w_rd     = IRIn[10:8];
  assign w_rs     = IRIn[7:5];
  assign w_zero   = StatusIn[1];
  assign w_unused = ^{StatusIn[dataWordSize-1:2], StatusIn[0], IRIn[4:2]};

  assign selMuxDataReg = 1'b0;
  assign loadB2MB      = 1'b0;
  assign iWrite        = 1'b0;

  // State register
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) r_state <= S_FETCH0;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH0: if (run) w_next_state = S_FETCH1;
      S_FETCH1: w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_HALT)                       w_next_state = S_HALT;
        else if (w_op == OP_LD || w_op == OP_CALL) w_next_state = S_EXEC2;
        else                                       w_next_state = S_FETCH0;
      end
      S_EXEC2: w_next_state = S_FETCH0;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH0;
    endcase
  end

  // Output decode; the second cycle of CALL reuses the JMP decode
  always_comb begin
    a1         = '0;
    a2         = '0;
    aWrite     = '0;
    loadReg    = 1'b0;
    incPC      = 1'b0;
    loadPCL    = 1'b0;
    loadPCH    = 1'b0;
    loadIRL    = 1'b0;
    loadIRH    = 1'b0;
    selMux1    = M1_REG;
    selMux2    = M2_ALU;
    loadLR     = 1'b0;
    loadSR     = 1'b0;
    dWrite     = 1'b0;
    loadLEDH   = 1'b0;
    loadLEDL   = 1'b0;
    opcode     = 5'd0;
    func       = 2'd0;
    loadStatus = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH1: begin
        selMux2 = M2_IMEM;
        loadIRH = 1'b1;
        loadIRL = 1'b1;
        incPC   = 1'b1;
      end
      S_EXEC: begin
        if (w_op[4] == 1'b0) begin
          if (w_op != OP_NOP) begin
            a1         = w_rd;
            a2         = w_rs;
            opcode     = w_op;
            func       = IRIn[1:0];
            aWrite     = w_rd;
            loadReg    = 1'b1;
            loadStatus = 1'b1;
          end
        end else begin
          case (w_op)
            OP_LDI: begin
              selMux1 = M1_IMM;
              selMux2 = M2_BUS1;
              aWrite  = w_rd;
              loadReg = 1'b1;
            end
            OP_LD: ;
            OP_ST: begin
              a2     = w_rd;
              dWrite = 1'b1;
            end
            OP_LDSR: begin
              a2     = w_rd;
              loadSR = 1'b1;
            end
            OP_IN: begin
              selMux2 = IRIn[0] ? M2_BTNH : M2_BTNL;
              aWrite  = w_rd;
              loadReg = 1'b1;
            end
            OP_OUT: begin
              a2       = w_rd;
              selMux2  = M2_BUS1;
              loadLEDH = IRIn[0];
              loadLEDL = ~IRIn[0];
            end
            OP_JMP: begin
              selMux1 = M1_IMM;
              selMux2 = M2_BUS1;
              loadPCL = 1'b1;
              loadPCH = 1'b1;
            end
            OP_JZ: begin
              if (w_zero) begin
                selMux1 = M1_IMM;
                selMux2 = M2_BUS1;
                loadPCL = 1'b1;
                loadPCH = 1'b1;
              end
            end
            OP_CALL: begin
              selMux1 = M1_PC;
              loadLR  = 1'b1;
            end
            OP_RET: begin
              selMux2 = M2_LR;
              loadPCL = 1'b1;
              loadPCH = 1'b1;
            end
            OP_HALT: ;
            default: illegal = 1'b1;
          endcase
        end
      end
      S_EXEC2: begin
        if (w_op == OP_LD) begin
          selMux2 = M2_DMEM;
          aWrite  = w_rd;
          loadReg = 1'b1;
        end else if (w_op == OP_CALL) begin
          selMux1 = M1_IMM;
          selMux2 = M2_BUS1;
          loadPCL = 1'b1;
          loadPCH = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
